// File: rtl/timer_pkg.sv
// Shared types, 7-segment encodings and digit helpers for the timer digit chain.
// Pure combinational helpers: no latency, no flow control.
package timer_pkg;

    typedef logic [3:0] bcd_t;

    // Active-low encodings, bit order {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_ZERO  = 7'b0000001;
    localparam logic [6:0] SEG_ONE   = 7'b1001111;
    localparam logic [6:0] SEG_TWO   = 7'b0010010;
    localparam logic [6:0] SEG_THREE = 7'b0000110;
    localparam logic [6:0] SEG_FOUR  = 7'b1001100;
    localparam logic [6:0] SEG_FIVE  = 7'b0100100;
    localparam logic [6:0] SEG_SIX   = 7'b0100000;
    localparam logic [6:0] SEG_SEVEN = 7'b0001111;
    localparam logic [6:0] SEG_EIGHT = 7'b0000000;
    localparam logic [6:0] SEG_NINE  = 7'b0000100;

    function automatic logic [6:0] seg_encode(input bcd_t bcd, input logic active_low);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_ZERO;
            4'd1:    seg = SEG_ONE;
            4'd2:    seg = SEG_TWO;
            4'd3:    seg = SEG_THREE;
            4'd4:    seg = SEG_FOUR;
            4'd5:    seg = SEG_FIVE;
            4'd6:    seg = SEG_SIX;
            4'd7:    seg = SEG_SEVEN;
            4'd8:    seg = SEG_EIGHT;
            4'd9:    seg = SEG_NINE;
            default: seg = 7'b1111111;
        endcase
        return active_low ? seg : ~seg;
    endfunction

    function automatic bcd_t clamp_digit(input bcd_t bcd, input bcd_t max);
        return (bcd > max) ? max : bcd;
    endfunction

endpackage

// File: rtl/timer_digit_chain_if.sv
// Control and display bundle of the timer digit chain.
// Level signals only; no handshake, the chain accepts a tick every cycle.
interface timer_digit_chain_if #(
    parameter int NUM_DIGITS = 6
);
    logic                    tick_en;
    logic                    count_down;
    logic                    clear;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] load_bcd;
    logic [4*NUM_DIGITS-1:0] digit_bcd;
    logic [7*NUM_DIGITS-1:0] seg_out;
    logic                    carry_out;
    logic                    zero_flag;

    modport master (
        output tick_en, count_down, clear, load, load_bcd,
        input  digit_bcd, seg_out, carry_out, zero_flag
    );

    modport slave (
        input  tick_en, count_down, clear, load, load_bcd,
        output digit_bcd, seg_out, carry_out, zero_flag
    );
endinterface

// File: rtl/timer_digit_stage.sv
// One registered modulo-(DIGIT_MAX+1) BCD digit with its 7-segment image.
// Latency 1 cycle from inc/dec/load/clear to value and seg; no backpressure.
module timer_digit_stage
    import timer_pkg::*;
#(
    parameter bcd_t DIGIT_MAX      = 4'd9,
    parameter bit   SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       load,
    input  bcd_t       load_val,
    input  logic       inc,
    input  logic       dec,
    input  logic       wrap_override,
    input  bcd_t       override_val,
    output bcd_t       value,
    output bcd_t       value_nxt,
    output logic [6:0] seg,
    output logic       at_max,
    output logic       at_zero
);

    bcd_t       value_q, value_d;
    logic [6:0] seg_q, seg_d;

    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = 4'd0;
        end else if (load) begin
            value_d = load_val;
        end else if (wrap_override) begin
            value_d = override_val;
        end else if (inc) begin
            value_d = at_max ? 4'd0 : value_q + 4'd1;
        end else if (dec) begin
            value_d = at_zero ? DIGIT_MAX : value_q - 4'd1;
        end
        seg_d = seg_encode(value_d, SEG_ACTIVE_LOW);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= 4'd0;
            seg_q   <= seg_encode(4'd0, SEG_ACTIVE_LOW);
        end else begin
            value_q <= value_d;
            seg_q   <= seg_d;
        end
    end

    assign value     = value_q;
    assign value_nxt = value_d;
    assign seg       = seg_q;
    assign at_max    = (value_q == DIGIT_MAX);
    assign at_zero   = (value_q == 4'd0);

endmodule

// File: rtl/timer_digit_chain.sv
// N-digit BCD up/down counter chain with clamped preset, optional 23<->00 hour pair and 7-seg outputs.
// Latency 1 cycle from tick/load/clear to all outputs; no backpressure, every cycle is accepted.
module timer_digit_chain
    import timer_pkg::*;
#(
    parameter int                    NUM_DIGITS     = 6,
    parameter logic [4*NUM_DIGITS-1:0] DIGIT_MAX    = {4'd2, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9},
    parameter bit                    HOUR24         = 1'b1,
    parameter bit                    SEG_ACTIVE_LOW = 1'b1,
    parameter bit                    STOP_AT_ZERO   = 1'b0
) (
    input  logic                 timer_clk,
    input  logic                 int_reset,
    timer_digit_chain_if.slave   bus
);

    localparam bit HOUR_EN = HOUR24 && (NUM_DIGITS >= 2);
    localparam int HI      = NUM_DIGITS - 1;
    localparam int LO      = (NUM_DIGITS >= 2) ? NUM_DIGITS - 2 : 0;

    logic [NUM_DIGITS-1:0] inc, dec, at_max, at_zero, ovr;
    bcd_t                  value     [NUM_DIGITS];
    bcd_t                  value_nxt [NUM_DIGITS];
    bcd_t                  ld_val    [NUM_DIGITS];
    bcd_t                  ovr_val   [NUM_DIGITS];
    logic [6:0]            seg       [NUM_DIGITS];
    logic                  tick_up, tick_dn, all_zero, hour_is_23, wrap_up, wrap_dn;
    logic                  carry_d, carry_q, zero_d, zero_q;

    assign all_zero = &at_zero;
    assign tick_up  = bus.tick_en & ~bus.count_down;
    assign tick_dn  = bus.tick_en & bus.count_down & ~(STOP_AT_ZERO && all_zero);

    // Prefix carry/borrow: a digit moves only when every lower digit is terminal.
    always_comb begin
        logic run_up, run_dn;
        run_up = tick_up;
        run_dn = tick_dn;
        inc    = '0;
        dec    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            inc[i] = run_up;
            dec[i] = run_dn;
            run_up = run_up & at_max[i];
            run_dn = run_dn & at_zero[i];
        end
    end

    // The hour pair wraps as a unit: 23 -> 00 going up, 00 -> 23 going down.
    always_comb begin
        hour_is_23 = HOUR_EN && (value[HI] == 4'd2) && (value[LO] == 4'd3);
        wrap_up    = HOUR_EN ? (inc[LO] & hour_is_23) : (inc[HI] & at_max[HI]);
        wrap_dn    = dec[HI] & at_zero[HI];
        ovr        = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            ovr_val[i] = 4'd0;
        end
        if (HOUR_EN) begin
            ovr[HI]     = wrap_up | wrap_dn;
            ovr[LO]     = wrap_up | wrap_dn;
            ovr_val[HI] = wrap_dn ? 4'd2 : 4'd0;
            ovr_val[LO] = wrap_dn ? 4'd3 : 4'd0;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            ld_val[i] = clamp_digit(bus.load_bcd[4*i +: 4], DIGIT_MAX[4*i +: 4]);
        end
        if (HOUR_EN && (ld_val[HI] == 4'd2) && (ld_val[LO] > 4'd3)) begin
            ld_val[LO] = 4'd3;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        timer_digit_stage #(
            .DIGIT_MAX      (DIGIT_MAX[4*g +: 4]),
            .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
        ) u_stage (
            .clk           (timer_clk),
            .rst           (int_reset),
            .clear         (bus.clear),
            .load          (bus.load),
            .load_val      (ld_val[g]),
            .inc           (inc[g]),
            .dec           (dec[g]),
            .wrap_override (ovr[g]),
            .override_val  (ovr_val[g]),
            .value         (value[g]),
            .value_nxt     (value_nxt[g]),
            .seg           (seg[g]),
            .at_max        (at_max[g]),
            .at_zero       (at_zero[g])
        );
    end

    always_comb begin
        carry_d = ~bus.clear & ~bus.load & (wrap_up | wrap_dn);
        zero_d  = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (value_nxt[i] != 4'd0) zero_d = 1'b0;
        end
    end

    always_ff @(posedge timer_clk or posedge int_reset) begin
        if (int_reset) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        bus.digit_bcd = '0;
        bus.seg_out   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            bus.digit_bcd[4*i +: 4] = value[i];
            bus.seg_out[7*i +: 7]   = seg[i];
        end
    end

    assign bus.carry_out = carry_q;
    assign bus.zero_flag = zero_q;

endmodule

// File: tb/tb_timer_digit_chain.sv
// Bench for timer_digit_chain: a 24h default instance, a stop-at-zero instance and a 4-digit decimal active-high instance.
module tb_timer_digit_chain;

    localparam logic [6:0] SEG_TAB [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    typedef struct packed {
        logic        t, dn, cl, ld;
        logic [23:0] lb;
        logic [23:0] eb;
        logic        ec, ez;
    } vec_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [23:0] bcd;
        logic [41:0] seg;
        logic        carry, zero;
    } sb_t;

    logic timer_clk = 1'b0;
    logic int_reset;
    int   errors = 0;
    int   checks = 0;
    sb_t  sb_q [$];
    vec_t vecs [$];

    always #5 timer_clk = ~timer_clk;

    timer_digit_chain_if #(.NUM_DIGITS(6)) ia ();
    timer_digit_chain_if #(.NUM_DIGITS(6)) ib ();
    timer_digit_chain_if #(.NUM_DIGITS(4)) ic ();

    timer_digit_chain u_a (.timer_clk(timer_clk), .int_reset(int_reset), .bus(ia));
    timer_digit_chain #(.STOP_AT_ZERO(1'b1)) u_b (.timer_clk(timer_clk), .int_reset(int_reset), .bus(ib));
    timer_digit_chain #(
        .NUM_DIGITS(4), .DIGIT_MAX(16'h9999), .HOUR24(1'b0), .SEG_ACTIVE_LOW(1'b0)
    ) u_c (.timer_clk(timer_clk), .int_reset(int_reset), .bus(ic));

    function automatic logic [41:0] seg_model(input logic [23:0] bcd, input int nd, input logic act_low);
        logic [41:0] s;
        logic [3:0]  d;
        s = '0;
        for (int i = 0; i < nd; i++) begin
            d = bcd[4*i +: 4];
            s[7*i +: 7] = act_low ? SEG_TAB[d] : ~SEG_TAB[d];
        end
        return s;
    endfunction

    function automatic vec_t mk(input logic t, dn, cl, ld, input logic [23:0] lb,
                                input logic [23:0] eb, input logic ec, ez);
        vec_t v;
        v.t = t; v.dn = dn; v.cl = cl; v.ld = ld; v.lb = lb;
        v.eb = eb; v.ec = ec; v.ez = ez;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_all();
        ia.tick_en = 0; ia.count_down = 0; ia.clear = 0; ia.load = 0; ia.load_bcd = '0;
        ib.tick_en = 0; ib.count_down = 0; ib.clear = 0; ib.load = 0; ib.load_bcd = '0;
        ic.tick_en = 0; ic.count_down = 0; ic.clear = 0; ic.load = 0; ic.load_bcd = '0;
    endtask

    task automatic push_exp(input int id, input logic [23:0] eb, input logic ec, ez);
        sb_t e;
        e.id    = 2'(id);
        e.bcd   = eb;
        e.seg   = seg_model(eb, (id == 2) ? 4 : 6, id != 2);
        e.carry = ec;
        e.zero  = ez;
        sb_q.push_back(e);
    endtask

    task automatic check_out(input string nm);
        sb_t         e;
        logic [23:0] ab;
        logic [41:0] as;
        logic        ac, az;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got nothing, expected an entry", nm);
            return;
        end
        e = sb_q.pop_front();
        case (e.id)
            2'd0:    begin ab = ia.digit_bcd; as = ia.seg_out; ac = ia.carry_out; az = ia.zero_flag; end
            2'd1:    begin ab = ib.digit_bcd; as = ib.seg_out; ac = ib.carry_out; az = ib.zero_flag; end
            default: begin
                ab = {8'h0, ic.digit_bcd}; as = {14'h0, ic.seg_out};
                ac = ic.carry_out;         az = ic.zero_flag;
            end
        endcase
        chk({nm, ".bcd"},   64'(ab), 64'(e.bcd));
        chk({nm, ".seg"},   64'(as), 64'(e.seg));
        chk({nm, ".carry"}, 64'(ac), 64'(e.carry));
        chk({nm, ".zero"},  64'(az), 64'(e.zero));
    endtask

    // Called at a falling edge: drive, push expectation, clock once, compare at the next falling edge.
    task automatic step(input int id, input logic t, dn, cl, ld, input logic [23:0] lb,
                        input logic [23:0] eb, input logic ec, ez, input string nm);
        case (id)
            0:       begin ia.tick_en = t; ia.count_down = dn; ia.clear = cl; ia.load = ld; ia.load_bcd = lb; end
            1:       begin ib.tick_en = t; ib.count_down = dn; ib.clear = cl; ib.load = ld; ib.load_bcd = lb; end
            default: begin ic.tick_en = t; ic.count_down = dn; ic.clear = cl; ic.load = ld; ic.load_bcd = lb[15:0]; end
        endcase
        push_exp(id, eb, ec, ez);
        @(posedge timer_clk);
        @(negedge timer_clk);
        idle_all();
        check_out(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish, got timeout, expected end of test");
        $fatal(1, "timeout");
    end

    initial begin
        vecs.push_back(mk(0, 0, 0, 1, 24'h235958, 24'h235958, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 24'h0,      24'h235959, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 24'h0,      24'h000000, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 24'h0,      24'h000000, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 24'h200000, 24'h200000, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 24'h0,      24'h195959, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 24'h0,      24'h000000, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 24'h0,      24'h235959, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 24'h0,      24'h235959, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 24'h100000, 24'h100000, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 24'h399999, 24'h235959, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 24'h050505, 24'h000000, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 24'h000005, 24'h000005, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 24'h0,      24'h000006, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 24'h0,      24'h000005, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 24'h0,      24'h000006, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 24'h0,      24'h000005, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 24'h095959, 24'h095959, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 24'h0,      24'h100000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 24'h240000, 24'h230000, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 24'h0,      24'h225959, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 24'h195959, 24'h195959, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 24'h0,      24'h200000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 24'h000001, 24'h000001, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 24'h0,      24'h000000, 0, 1));

        idle_all();
        int_reset = 1'b1;
        @(posedge timer_clk);
        @(negedge timer_clk);
        push_exp(0, 24'h0, 0, 1); check_out("reset_a");
        push_exp(2, 24'h0, 0, 1); check_out("reset_c");
        int_reset = 1'b0;

        // A carry pending at the moment of reset must be dropped.
        step(0, 0, 0, 0, 1, 24'h235959, 24'h235959, 0, 0, "pre_wrap");
        step(0, 1, 0, 0, 0, 24'h0,      24'h000000, 1, 1, "wrap_pulse");
        int_reset = 1'b1;
        #1;
        chk("reset_kills_carry", 64'(ia.carry_out), 64'(0));
        @(negedge timer_clk);
        int_reset = 1'b0;

        // Reset asserted mid-count while a tick is requested.
        step(0, 0, 0, 0, 1, 24'h123456, 24'h123456, 0, 0, "load_123456");
        ia.tick_en = 1'b1;
        int_reset  = 1'b1;
        @(posedge timer_clk);
        @(negedge timer_clk);
        push_exp(0, 24'h0, 0, 1); check_out("reset_mid");
        int_reset  = 1'b0;
        ia.tick_en = 1'b0;
        step(0, 0, 0, 0, 0, 24'h0, 24'h000000, 0, 1, "after_reset_hold");

        for (int i = 0; i < vecs.size(); i++) begin
            step(0, vecs[i].t, vecs[i].dn, vecs[i].cl, vecs[i].ld, vecs[i].lb,
                 vecs[i].eb, vecs[i].ec, vecs[i].ez, $sformatf("vec%0d", i));
        end

        step(1, 0, 0, 0, 1, 24'h200000, 24'h200000, 0, 0, "b_load");
        step(1, 1, 1, 0, 0, 24'h0,      24'h195959, 0, 0, "b_down");
        step(1, 0, 0, 1, 0, 24'h0,      24'h000000, 0, 1, "b_clear");
        step(1, 1, 1, 0, 0, 24'h0,      24'h000000, 0, 1, "b_stop0");
        step(1, 1, 0, 0, 0, 24'h0,      24'h000001, 0, 0, "b_up");
        step(1, 1, 1, 0, 0, 24'h0,      24'h000000, 0, 1, "b_down0");
        step(1, 1, 1, 0, 0, 24'h0,      24'h000000, 0, 1, "b_stop1");

        step(2, 0, 0, 0, 1, 24'h9998, 24'h9998, 0, 0, "c_load");
        step(2, 1, 0, 0, 0, 24'h0,    24'h9999, 0, 0, "c_up1");
        step(2, 1, 0, 0, 0, 24'h0,    24'h0000, 1, 1, "c_wrap");
        step(2, 0, 0, 0, 0, 24'h0,    24'h0000, 0, 1, "c_idle");
        step(2, 0, 0, 0, 1, 24'h8888, 24'h8888, 0, 0, "c_load8");
        chk("c_seg8", 64'(ic.seg_out[6:0]), 64'(7'b1111111));
        step(2, 0, 0, 1, 0, 24'h0,    24'h0000, 0, 1, "c_clear");
        step(2, 1, 1, 0, 0, 24'h0,    24'h9999, 1, 0, "c_down_wrap");
        step(2, 1, 0, 0, 0, 24'h0,    24'h0000, 1, 1, "c_up_wrap");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer_digit_chain.md
Name: timer_digit_chain

Overview:
- Parametrised N-digit BCD counter chain with per-digit modulus, up/down mode, preset load and 7-segment outputs.
- Generalises the single-digit ripple iterator into one block. All carries are resolved combinationally inside the chain, so every digit updates on the same edge and there is no per-stage overflow latency.
- Default configuration is a 24-hour HH:MM:SS clock/countdown timer. The block drives the display muxing logic directly.

Parameters:
- NUM_DIGITS, 6: number of digits; digit 0 is least significant.
- DIGIT_MAX, {4'd2,4'd9,4'd5,4'd9,4'd5,4'd9}: packed 4*NUM_DIGITS; max value per digit (digit i at bits [4i+3:4i]). Each entry is 1..9.
- HOUR24, 1: top two digits form an hour pair that wraps 23<->00. Requires NUM_DIGITS>=2 and top DIGIT_MAX entries 2 and 9.
- SEG_ACTIVE_LOW, 1: 1 means segment-on drives 0.
- STOP_AT_ZERO, 0: 1 means down-count holds at all-zero instead of wrapping.

Ports:
- timer_clk  in  1  counting clock.
- int_reset  in  1  asynchronous reset, active-high.
- tick_en  in  1  advance chain by one count this cycle.
- count_down  in  1  0 = up, 1 = down; sampled with tick_en.
- clear  in  1  synchronous clear to all-zero.
- load  in  1  synchronous preset.
- load_bcd  in  4*NUM_DIGITS  preset value, BCD per digit.
- digit_bcd  out  4*NUM_DIGITS  registered BCD digit values.
- seg_out  out  7*NUM_DIGITS  registered 7-seg per digit, bit order {a,b,c,d,e,f,g}.
- carry_out  out  1  one-cycle pulse on chain wrap.
- zero_flag  out  1  registered; high when all digits are 0.

Behaviour:
- Reset (async, int_reset=1):
  - digit_bcd=0 and seg_out = encoding of 0 for all digits (active-low: 7'b0000001).
  - carry_out=0, zero_flag=1.
  - Deasserting reset mid-count restarts from zero. No pending carry survives reset.
- Priority per edge: clear > load > tick_en. Inactive inputs leave all state held and carry_out=0.
- Clear: all digits 0, zero_flag=1, carry_out=0.
- Load:
  - Each digit takes min(load_bcd field, DIGIT_MAX field). Values above 9 also clamp.
  - If HOUR24 and the resulting hour pair >23, the pair becomes 23.
  - carry_out=0. zero_flag is updated from the loaded value.
- Up tick:
  - Digit i increments when all lower digits are at their max. Digit 0 always increments.
  - A digit at max wraps to 0.
  - HOUR24: when the hour pair is 23 and all lower digits are at max, the pair goes to 00.
  - Chain wrap (all digits were at terminal value) → carry_out=1 for the following cycle.
- Down tick:
  - Digit i decrements when all lower digits are 0. A digit at 0 wraps to its max.
  - HOUR24: hour pair 00 with all lower digits zero goes to 23, not 29.
  - All-zero chain wraps to all-max (e.g. 23:59:59) with carry_out=1.
  - If STOP_AT_ZERO=1, a down tick at all-zero is ignored: no change, carry_out=0.
- Direction may change on any cycle. Only the value sampled with tick_en matters.
- seg_out is registered on the same edge as digit_bcd; latency from tick_en to both outputs is 1 cycle.
- Segment encoding (active-low), with SEG_ACTIVE_LOW=0 giving the bitwise inverse:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
- zero_flag is registered and reflects digit_bcd after the same edge.

Decomposition:
- Package timer_pkg:
  - SEG_ZERO..SEG_NINE constants.
  - Function seg_encode(bcd, active_low).
  - Function clamp_digit(bcd, max).
  - Typedef bcd_t (logic [3:0]).
- Sub-module timer_digit_stage: one registered modulo digit.
  - Inputs: inc, dec, wrap_override with override value, load/clear.
  - Outputs: value, at_max, at_zero.
  - Generated NUM_DIGITS times.
- Parent owns the carry/borrow prefix logic, HOUR24 pair handling, carry_out and zero_flag.

Test Plan:
- Reset mid-count at 12:34:56 → next cycle all digits 0, seg_out all 7'b0000001, zero_flag=1, carry_out=0.
- Load 23:59:58, two up ticks → 23:59:59, then 00:00:00 with carry_out high exactly one cycle. No intermediate 24:xx.
- Load 20:00:00, one down tick → 19:59:59. Clear, one down tick → 23:59:59 and carry_out pulse. Repeat with STOP_AT_ZERO=1 → stays 00:00:00, no pulse.
- Load 39:99:99 → clamped to 23:59:59. Same cycle with tick_en=1 → load wins, no count.
- Clear and load asserted together at 05:05:05 → 00:00:00 (clear wins). tick_en with count_down toggling each cycle from 00:00:05 → 06,05,06,05.
- NUM_DIGITS=4, DIGIT_MAX={9,9,9,9}, HOUR24=0, SEG_ACTIVE_LOW=0 → counts 9999 → 0000 with carry pulse. seg_out for 8 = 7'b1111111.
